rtc_alarm_sched: RTL

RTC_ALARM_SCHED -- requirements
Module: rtc_alarm_sched

---
 rtl/rtc_alarm_sched.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/rtc_alarm_sched.sv
// Alarm scheduler for an APB2 RTC: keeps NSLOT pending alarm times, programs
// the RTC match register with the earliest one and reports each expiry.
`timescale 1ns/1ps
module rtc_alarm_sched #(
  parameter int NSLOT = 4
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             AlarmReq,
  input  logic             AlarmCancel,
  input  logic [2:0]       AlarmIdx,
  input  logic [31:0]      AlarmTime,
  input  logic             RTCINTR,
  input  logic [31:0]      PRDATA,
  output logic             PSEL,
  output logic             PENABLE,
  output logic             PWRITE,
  output logic [9:0]       PADDR,
  output logic [31:0]      PWDATA,
  output logic             AlarmFired,
  output logic [2:0]       AlarmFiredIdx,
  output logic [NSLOT-1:0] AlarmPend,
  output logic             Busy
);
  localparam int         IW      = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam logic [3:0] NSLOT_L = 4'(NSLOT);

  typedef enum logic [2:0] {INIT, IDLE, CLR, RDDR, EVAL, WRMR} state_t;

  state_t           state, state_nxt;
  logic             acc, acc_nxt;
  logic [NSLOT-1:0] pend, pend_nxt;
  logic             dirty, dirty_nxt;
  logic             armed, armed_nxt;
  logic             stale, stale_nxt;
  logic [2:0]       armed_idx, armed_idx_nxt;
  logic [2:0]       sel_idx, sel_idx_nxt;
  logic [31:0]      now, now_nxt;
  logic             fire, fire_nxt;
  logic [2:0]       fire_idx, fire_idx_nxt;
  logic [31:0]      slot_time [NSLOT];
  logic [31:0]      sel_time;

  logic             req_ok, hit_armed;
  logic [IW-1:0]    ridx;
  logic [31:0]      now1, min_time;
  logic             due_found, min_found;
  logic [2:0]       due_idx, min_idx;
  logic             xfer;

  assign req_ok    = AlarmReq && ({1'b0, AlarmIdx} < NSLOT_L);
  assign ridx      = AlarmIdx[IW-1:0];
  assign hit_armed = req_ok && armed && (AlarmIdx == armed_idx);

  // Scan slots: lowest-index due slot, and earliest pending slot (ties low)
  always_comb begin
    now1      = now + 32'd1;
    due_found = 1'b0;
    due_idx   = 3'd0;
    min_found = 1'b0;
    min_idx   = 3'd0;
    min_time  = 32'd0;
    for (int i = 0; i < NSLOT; i++) begin
      if (pend[i] && (slot_time[i] <= now1) && !due_found) begin
        due_found = 1'b1;
        due_idx   = 3'(i);
      end
      if (pend[i] && (!min_found || (slot_time[i] < min_time))) begin
        min_found = 1'b1;
        min_idx   = 3'(i);
        min_time  = slot_time[i];
      end
    end
  end

  // Next-state logic; host requests applied last so they win over FSM clears
  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    pend_nxt      = pend;
    dirty_nxt     = dirty;
    armed_nxt     = armed;
    armed_idx_nxt = armed_idx;
    sel_idx_nxt   = sel_idx;
    stale_nxt     = stale;
    now_nxt       = now;
    fire_nxt      = 1'b0;
    fire_idx_nxt  = fire_idx;
    case (state)
      INIT: begin
        acc_nxt = ~acc;
        if (acc) state_nxt = IDLE;
      end
      IDLE: begin
        if (RTCINTR)    state_nxt = CLR;
        else if (dirty) state_nxt = RDDR;
      end
      CLR: begin
        acc_nxt = ~acc;
        if (acc) begin
          state_nxt = IDLE;
          // A request hitting the armed slot this cycle makes the match stale
          if (armed && !hit_armed) begin
            pend_nxt[armed_idx[IW-1:0]] = 1'b0;
            fire_nxt     = 1'b1;
            fire_idx_nxt = armed_idx;
            armed_nxt    = 1'b0;
            dirty_nxt    = 1'b1;
          end
        end
      end
      RDDR: begin
        acc_nxt = ~acc;
        if (acc) begin
          now_nxt   = PRDATA;
          state_nxt = EVAL;
        end
      end
      EVAL: begin
        state_nxt = IDLE;
        if (due_found) begin
          pend_nxt[due_idx[IW-1:0]] = 1'b0;
          fire_nxt     = 1'b1;
          fire_idx_nxt = due_idx;
          if (armed && (armed_idx == due_idx)) armed_nxt = 1'b0;
        end else if (min_found) begin
          sel_idx_nxt = min_idx;
          stale_nxt   = 1'b0;
          dirty_nxt   = 1'b0;
          state_nxt   = WRMR;
        end else begin
          armed_nxt = 1'b0;
          dirty_nxt = 1'b0;
        end
      end
      WRMR: begin
        acc_nxt = ~acc;
        if (req_ok && (AlarmIdx == sel_idx)) stale_nxt = 1'b1;
        if (acc) begin
          armed_nxt     = !(stale || (req_ok && (AlarmIdx == sel_idx)));
          armed_idx_nxt = sel_idx;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = INIT;
    endcase
    if (req_ok) begin
      pend_nxt[ridx] = ~AlarmCancel;
      dirty_nxt      = 1'b1;
      if (armed_nxt && (AlarmIdx == armed_idx_nxt)) armed_nxt = 1'b0;
    end
  end

  // Control state register
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state     <= INIT;
      acc       <= 1'b0;
      pend      <= '0;
      dirty     <= 1'b0;
      armed     <= 1'b0;
      stale     <= 1'b0;
      armed_idx <= 3'd0;
      sel_idx   <= 3'd0;
      now       <= 32'd0;
      fire      <= 1'b0;
      fire_idx  <= 3'd0;
    end else begin
      state     <= state_nxt;
      acc       <= acc_nxt;
      pend      <= pend_nxt;
      dirty     <= dirty_nxt;
      armed     <= armed_nxt;
      stale     <= stale_nxt;
      armed_idx <= armed_idx_nxt;
      sel_idx   <= sel_idx_nxt;
      now       <= now_nxt;
      fire      <= fire_nxt;
      fire_idx  <= fire_idx_nxt;
    end
  end

  // Alarm time storage and the time being written to the match register
  always_ff @(posedge PCLK) begin
    if (req_ok && !AlarmCancel) slot_time[ridx] <= AlarmTime;
    if ((state == EVAL) && !due_found && min_found) sel_time <= min_time;
  end

  // APB master outputs decoded from state/phase; reset drops them at once
  always_comb begin
    xfer    = ((state == INIT) || (state == CLR) || (state == RDDR) ||
               (state == WRMR)) && !PRESET;
    PSEL    = xfer;
    PENABLE = xfer && acc;
    PWRITE  = xfer && (state != RDDR);
    PADDR   = 10'h000;
    PWDATA  = 32'd0;
    if (xfer) begin
      case (state)
        INIT:    begin PADDR = 10'h004; PWDATA = 32'd1;    end
        CLR:     begin PADDR = 10'h007; PWDATA = 32'd1;    end
        WRMR:    begin PADDR = 10'h001; PWDATA = sel_time; end
        default: begin PADDR = 10'h000; PWDATA = 32'd0;    end
      endcase
    end
  end

  assign AlarmFired    = fire;
  assign AlarmFiredIdx = fire_idx;
  assign AlarmPend     = pend;
  assign Busy          = (state != IDLE);
endmodule
